// File: rtl/sevenseg_pkg.sv
// Shared types, segment patterns and sizing helper for the seven-segment scan display.
// Optional feature macro: LEADING_ZERO_BLANK_EN.
package sevenseg_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } conv_state_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}
  localparam seg_t SEG_LUT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic int min_digits(int bits);
    longint unsigned v;
    int d;
    v = (64'd1 << bits) - 64'd1;
    d = 0;
    while (v != 0) begin
      v = v / 10;
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/sevenseg_scan_display_if.sv
// Number input and display outputs of the seven-segment scan display.
// master drives the number, slave is the display block.
interface sevenseg_scan_display_if #(
  parameter int BITS = 8
);

  logic [BITS-1:0] number;
  logic [7:0]      anode;
  logic [6:0]      segments;
  logic            dp;
  logic            busy;

  modport master (
    output number,
    input  anode, segments, dp, busy
  );

  modport slave (
    input  number,
    output anode, segments, dp, busy
  );

endinterface

// File: rtl/bcd_to_sevenseg.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Non-decimal codes decode to a blank digit.
module bcd_to_sevenseg
  import sevenseg_pkg::*;
(
  input  bcd_t i_bcd,
  output seg_t o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (i_bcd <= 4'd9) o_seg = SEG_LUT[i_bcd];
  end

endmodule

// File: rtl/sevenseg_scan_display.sv
// Sequential double-dabble conversion plus multiplexed 8-anode scan.
// Define LEADING_ZERO_BLANK_EN to blank zero digits above the most significant nonzero one.
module sevenseg_scan_display
  import sevenseg_pkg::*;
#(
  parameter int BITS        = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 100000
) (
  input logic clk,
  input logic rst,
  sevenseg_scan_display_if.slave bus
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int CW = $clog2(BITS + 1);

  if (DIGITS < min_digits(BITS) || DIGITS > 8) begin : g_bad_digits
    $error("DIGITS too small for BITS or above 8");
  end
  if (REFRESH_DIV < 2) begin : g_bad_div
    $error("REFRESH_DIV must be >= 2");
  end

  conv_state_t     r_state, w_next;
  logic [BITS-1:0] r_cap, r_bin;
  logic [W-1:0]    r_bcd, r_disp, w_adj;
  logic [CW-1:0]   r_cnt;
  logic            r_force;
  logic            w_start;
  logic            w_busy;

  assign w_start = r_force || (bus.number != r_cap);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_start) w_next = SHIFT;
      SHIFT:   if (r_cnt == CW'(BITS - 1)) w_next = LOAD;
      LOAD:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != IDLE);
  end

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++)
      if (r_bcd[i*4 +: 4] >= 4'd5)
        w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_force <= 1'b1;
      r_cap   <= '0;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_disp  <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (w_start) begin
          r_cap   <= bus.number;
          r_bin   <= bus.number;
          r_bcd   <= '0;
          r_cnt   <= '0;
          r_force <= 1'b0;
        end
        SHIFT: begin
          {r_bcd, r_bin} <= {w_adj[W-2:0], r_bin, 1'b0};
          r_cnt          <= r_cnt + CW'(1);
        end
        LOAD:    r_disp <= r_bcd;
        default: ;
      endcase
    end
  end

  logic [PW-1:0] r_pre;
  logic [2:0]    r_idx;
  logic [7:0]    r_anode;
  seg_t          r_seg;
  bcd_t          w_nib;
  seg_t          w_dec;
  logic [DIGITS-1:0] w_blank;
  logic          w_bsel;

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin : lz_blank
    logic v_zero;
    v_zero  = 1'b1;
    w_blank = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      v_zero     = v_zero & (r_disp[i*4 +: 4] == 4'd0);
      w_blank[i] = v_zero;
    end
  end
`else
  assign w_blank = '0;
`endif

  always_comb begin
    w_nib  = '0;
    w_bsel = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (r_idx == 3'(i)) begin
        w_nib  = r_disp[i*4 +: 4];
        w_bsel = w_blank[i];
      end
  end

  bcd_to_sevenseg u_dec (
    .i_bcd (w_nib),
    .o_seg (w_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre   <= '0;
      r_idx   <= '0;
      r_anode <= 8'hFF;
      r_seg   <= SEG_BLANK;
    end else begin
      if (r_pre == PW'(REFRESH_DIV - 1)) begin
        r_pre <= '0;
        r_idx <= (r_idx == 3'(DIGITS - 1)) ? 3'd0 : r_idx + 3'd1;
      end else begin
        r_pre <= r_pre + PW'(1);
      end
      r_anode <= ~(8'd1 << r_idx);
      r_seg   <= w_bsel ? SEG_BLANK : w_dec;
    end
  end

  assign bus.anode    = r_anode;
  assign bus.segments = r_seg;
  assign bus.dp       = 1'b1;
  assign bus.busy     = w_busy;

endmodule
